// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird game sequencer: state encoding,
// default score width and the per-cycle event bundle seen by the FSM.
package game_pkg;

  localparam int GAME_SCORE_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  typedef struct packed {
    logic press;
    logic frame_stb;
    logic out_of_bounds;
    logic pipe_passed;
  } evt_t;

endpackage

// File: rtl/game_ctrl_if.sv
// Game sequencer I/O bundle: button and bird-block events in, bird-block
// controls and score readout out.
interface game_ctrl_if #(parameter int SCORE_W = game_pkg::GAME_SCORE_W);

  logic               i_btn;
  logic               i_frame_stb;
  logic               i_out_of_bounds;
  logic               i_pipe_passed;
  logic               o_bird_rst;
  logic               o_animate;
  logic               o_flap;
  logic [1:0]         o_state;
  logic [SCORE_W-1:0] o_score;
  logic [SCORE_W-1:0] o_hi_score;

  modport slave (
    input  i_btn, i_frame_stb, i_out_of_bounds, i_pipe_passed,
    output o_bird_rst, o_animate, o_flap, o_state, o_score, o_hi_score
  );

  modport master (
    output i_btn, i_frame_stb, i_out_of_bounds, i_pipe_passed,
    input  o_bird_rst, o_animate, o_flap, o_state, o_score, o_hi_score
  );

endinterface

// File: rtl/btn_debounce.sv
// Flap button conditioner: 2-flop synchroniser, stability-count debounce and
// a registered one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        press_q, press_d;

  // Counter only advances while the synced input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_CYCLES - 16'd1) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign o_level = level_q;
  assign o_press = press_q;

endmodule

// File: rtl/game_ctrl.sv
// Flappy-bird game sequencer: IDLE/PLAY/DEAD/OVER FSM, bird-block control
// pulses and score keeping. Optional flap rate limit under FLAP_COOLDOWN_EN.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES       = 16'd50000,
  parameter logic [7:0]  DEAD_FRAMES     = 8'd60,
  parameter logic [3:0]  COOLDOWN_FRAMES = 4'd6,
  parameter int          SCORE_W         = GAME_SCORE_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  game_ctrl_if.slave  bus
);

  logic btn_level, btn_press;
  evt_t ev;
  logic death, cd_ok;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic [7:0]         dead_cnt_q, dead_cnt_d;
  logic               bird_rst_q, bird_rst_d;
  logic               flap_q, flap_d;
  logic               animate_q, animate_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (bus.i_btn),
    .o_level (btn_level),
    .o_press (btn_press)
  );

  assign ev = '{press:         btn_press & btn_level,
                frame_stb:     bus.i_frame_stb,
                out_of_bounds: bus.i_out_of_bounds,
                pipe_passed:   bus.i_pipe_passed};

  // Out-of-bounds is only trusted on frame boundaries.
  assign death = ev.frame_stb & ev.out_of_bounds;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    hi_d       = hi_q;
    dead_cnt_d = dead_cnt_q;
    bird_rst_d = 1'b0;
    flap_d     = 1'b0;
    animate_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (ev.press) begin
          state_d    = ST_PLAY;
          bird_rst_d = 1'b1;
          score_d    = '0;
        end
      end
      ST_PLAY: begin
        // Death wins: no pipe credit and no flap on the dying cycle.
        if (death) begin
          state_d    = ST_DEAD;
          dead_cnt_d = '0;
          if (score_q > hi_q) hi_d = score_q;
        end else begin
          animate_d = 1'b1;
          if (ev.pipe_passed && (score_q != '1)) score_d = score_q + SCORE_W'(1);
          if (ev.press && cd_ok) flap_d = 1'b1;
        end
      end
      ST_DEAD: begin
        if (ev.frame_stb) begin
          if (dead_cnt_q == DEAD_FRAMES - 8'd1) state_d = ST_OVER;
          else dead_cnt_d = dead_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

`ifdef FLAP_COOLDOWN_EN
  logic [3:0] cd_q, cd_d;

  always_comb begin
    cd_d = cd_q;
    if (state_d != ST_PLAY)               cd_d = '0;
    else if (flap_d)                      cd_d = COOLDOWN_FRAMES;
    else if (ev.frame_stb && cd_q != '0)  cd_d = cd_q - 4'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cd_q <= '0;
    else          cd_q <= cd_d;
  end

  assign cd_ok = (cd_q == '0);
`else
  logic unused_cd;
  assign unused_cd = ^COOLDOWN_FRAMES;
  assign cd_ok     = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      hi_q       <= '0;
      dead_cnt_q <= '0;
      bird_rst_q <= 1'b0;
      flap_q     <= 1'b0;
      animate_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      hi_q       <= hi_d;
      dead_cnt_q <= dead_cnt_d;
      bird_rst_q <= bird_rst_d;
      flap_q     <= flap_d;
      animate_q  <= animate_d;
    end
  end

  assign bus.o_bird_rst = bird_rst_q;
  assign bus.o_animate  = animate_q;
  assign bus.o_flap     = flap_q;
  assign bus.o_state    = state_q;
  assign bus.o_score    = score_q;
  assign bus.o_hi_score = hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random stimulus, checked each
// cycle against a window-based button model and an event-level game model.
module tb_game_ctrl;

  localparam int SW   = 10;
  localparam int DB   = 4;
  localparam int DF   = 3;
  localparam int CF   = 2;
  localparam int MAXS = (1 << SW) - 1;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;
  always #5 i_clk = ~i_clk;

  game_ctrl_if #(.SCORE_W(SW)) bus();

  game_ctrl #(
    .DB_CYCLES       (16'(DB)),
    .DEAD_FRAMES     (8'(DF)),
    .COOLDOWN_FRAMES (4'(CF)),
    .SCORE_W         (SW)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_flap = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model
  int m_mode, m_score, m_hi, m_dead_stb, m_since;
  bit m_press, m_lvl, m_rst, m_flap, m_anim;
  bit hist[$];

  task automatic model_reset();
    m_mode = 0; m_score = 0; m_hi = 0; m_dead_stb = 0; m_since = CF;
    m_press = 0; m_lvl = 0; m_rst = 0; m_flap = 0; m_anim = 0;
    hist = {};
    for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
  endtask

  task automatic model_step();
    bit win_diff, next_press, ok;
    int prev;
    // Button: level flips once the last DB synchronised samples (2 edges old) all disagree.
    hist.push_back(bus.i_btn);
    win_diff = 1;
    for (int j = 0; j < DB; j++)
      if (hist[hist.size() - 3 - j] == m_lvl) win_diff = 0;
    next_press = 0;
    if (win_diff) begin
      m_lvl = !m_lvl;
      next_press = m_lvl;
    end
    void'(hist.pop_front());

    m_rst = 0; m_flap = 0; prev = m_mode;
    case (m_mode)
      0, 3: if (m_press) begin m_mode = 1; m_score = 0; m_rst = 1; end
      1: begin
        if (bus.i_frame_stb && bus.i_out_of_bounds) begin
          m_mode = 2; m_dead_stb = 0; m_since = CF;
          if (m_score > m_hi) m_hi = m_score;
        end else begin
          if (bus.i_pipe_passed) m_score = (m_score + 1 > MAXS) ? MAXS : m_score + 1;
`ifdef FLAP_COOLDOWN_EN
          ok = (m_since >= CF);
`else
          ok = 1;
`endif
          if (m_press && ok) begin m_flap = 1; m_since = 0; end
          else if (bus.i_frame_stb && m_since < CF) m_since++;
        end
      end
      2: if (bus.i_frame_stb) begin
        m_dead_stb++;
        if (m_dead_stb == DF) m_mode = 3;
      end
      default: ;
    endcase
    m_anim  = (prev == 1) && (m_mode == 1);
    m_press = next_press;
  endtask

  task automatic compare_all();
    chk("state",    bus.o_state,    m_mode);
    chk("score",    bus.o_score,    m_score);
    chk("hi_score", bus.o_hi_score, m_hi);
    chk("bird_rst", bus.o_bird_rst, m_rst);
    chk("flap",     bus.o_flap,     m_flap);
    chk("animate",  bus.o_animate,  m_anim);
    chk("rst_flap_excl", bus.o_bird_rst & bus.o_flap, 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
    n_flap += int'(bus.o_flap);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press_btn();
    bus.i_btn = 1'b1; idle(8);
    bus.i_btn = 1'b0; idle(8);
  endtask

  task automatic strobe(input bit oob);
    bus.i_frame_stb = 1'b1; bus.i_out_of_bounds = oob; tick();
    bus.i_frame_stb = 1'b0; bus.i_out_of_bounds = 1'b0; tick();
  endtask

  task automatic pipe_pulse();
    bus.i_pipe_passed = 1'b1; tick();
    bus.i_pipe_passed = 1'b0; tick();
  endtask

  task automatic do_reset();
    bus.i_btn = 0; bus.i_frame_stb = 0; bus.i_out_of_bounds = 0; bus.i_pipe_passed = 0;
    i_rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_state", bus.o_state, 0);
    chk("rst_score", bus.o_score, 0);
    chk("rst_hi",    bus.o_hi_score, 0);
    chk("rst_ctl",   {bus.o_bird_rst, bus.o_flap, bus.o_animate}, 0);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  int f0, run_left;

  initial begin
    bus.i_btn = 0; bus.i_frame_stb = 0; bus.i_out_of_bounds = 0; bus.i_pipe_passed = 0;
    #1;
    do_reset();

    // Clean press from IDLE: bird reset 7 cycles after the rise, animate one later.
    bus.i_btn = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 6) chk("s1_no_rst_early", bus.o_bird_rst, 0);
      if (t == 7) begin
        chk("s1_bird_rst", bus.o_bird_rst, 1);
        chk("s1_state",    bus.o_state, 1);
        chk("s1_anim_lag", bus.o_animate, 0);
      end
      if (t == 8) begin
        chk("s1_animate",  bus.o_animate, 1);
        chk("s1_rst_once", bus.o_bird_rst, 0);
      end
    end
    bus.i_btn = 1'b0; idle(10);

    // Bouncy press: exactly one flap.
    f0 = n_flap;
    foreach (hist[i]) ; // keep model window untouched
    bus.i_btn = 1; tick(); bus.i_btn = 0; tick();
    bus.i_btn = 1; tick(); bus.i_btn = 0; tick();
    chk("s2_bounce_flap", n_flap - f0, 0);
    bus.i_btn = 1; idle(10);
    bus.i_btn = 0; idle(10);
    chk("s2_one_flap", n_flap - f0, 1);

    // Score three pipes, die, then DEAD_FRAMES strobes to OVER.
    repeat (3) pipe_pulse();
    chk("s3_score_pre", bus.o_score, 3);
    strobe(1'b1);
    chk("s3_state_dead", bus.o_state, 2);
    chk("s3_score",      bus.o_score, 3);
    chk("s3_hi",         bus.o_hi_score, 3);
    strobe(1'b0); strobe(1'b0);
    chk("s3_still_dead", bus.o_state, 2);
    strobe(1'b0);
    chk("s3_over", bus.o_state, 3);

    // Restart from OVER, then press + pipe + death on the same cycle.
    press_btn();
    chk("s4_play", bus.o_state, 1);
    chk("s4_score_clr", bus.o_score, 0);
    pipe_pulse();
    bus.i_btn = 1'b1; idle(6);
    f0 = n_flap;
    bus.i_pipe_passed = 1; bus.i_out_of_bounds = 1; bus.i_frame_stb = 1;
    tick();
    bus.i_pipe_passed = 0; bus.i_out_of_bounds = 0; bus.i_frame_stb = 0;
    chk("s4_dead",  bus.o_state, 2);
    chk("s4_score", bus.o_score, 1);
    chk("s4_hi",    bus.o_hi_score, 3);
    bus.i_btn = 1'b0; idle(10);
    chk("s4_no_flap", n_flap - f0, 0);
    repeat (DF) strobe(1'b0);

    // Saturating score.
    press_btn();
    bus.i_pipe_passed = 1'b1; idle(MAXS + 5);
    chk("s5_score_max", bus.o_score, MAXS);
    tick();
    bus.i_pipe_passed = 1'b0; tick();
    chk("s5_score_sat", bus.o_score, MAXS);
    strobe(1'b1);
    chk("s5_hi_max", bus.o_hi_score, MAXS);
    repeat (DF) strobe(1'b0);

    // Two presses inside one frame, then one after two strobes.
    press_btn();
    f0 = n_flap;
    press_btn(); press_btn();
`ifdef FLAP_COOLDOWN_EN
    chk("s6_cooldown_flaps", n_flap - f0, 1);
`else
    chk("s6_free_flaps", n_flap - f0, 2);
`endif
    strobe(1'b0); strobe(1'b0);
    f0 = n_flap;
    press_btn();
    chk("s6_flap_after", n_flap - f0, 1);

    // Random traffic.
    run_left = 0;
    for (int i = 0; i < 800; i++) begin
      if (run_left == 0) begin
        bus.i_btn = 1'($urandom_range(0, 1));
        run_left  = $urandom_range(1, 10);
      end
      run_left--;
      bus.i_frame_stb     = ($urandom_range(0, 7) == 0);
      bus.i_out_of_bounds = ($urandom_range(0, 5) == 0);
      bus.i_pipe_passed   = ($urandom_range(0, 4) == 0);
      tick();
    end
    bus.i_btn = 0; bus.i_frame_stb = 0; bus.i_out_of_bounds = 0; bus.i_pipe_passed = 0;
    idle(10);

    // Reset mid-game loses score and high score.
    if (bus.o_state != 2'd1) press_btn();
    pipe_pulse();
    do_reset();
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
